// File: rtl/ee201_pb_debouncer.sv
// -----------------------------------------------------------------------------
// ee201_pb_debouncer
//
// Push-button conditioner that follows ee201_clk_60Hz. The divider's Clk60
// level is sampled as data in the Clk domain. Each Clk60 rising edge is one
// debounce "tick". A raw button must be stable for N_DEBOUNCE ticks to be
// accepted or released. Once accepted, holding the button produces
// auto-repeat enables.
//
// Parameters:
//   N_DEBOUNCE - ticks of stable input needed to accept a press or release
//   N_HOLD     - ticks of hold after acceptance before auto-repeat begins
//   N_REPEAT   - ticks between auto-repeat pulses
//   CNT_WIDTH  - width of the tick counter (each N_* must be 1..2^CNT_WIDTH)
//
// Ports:
//   Clk   (in)  system clock, all state on the rising edge
//   Reset (in)  asynchronous, active-low reset
//   Clk60 (in)  60 Hz level from ee201_clk_60Hz (same Clk domain)
//   PB    (in)  raw, asynchronous, active-high push button
//   DPB   (out) debounced button level
//   SCEN  (out) one Clk pulse per accepted press
//   MCEN  (out) one Clk pulse on press and on every auto-repeat
//   CCEN  (out) high every Clk while the button is held (HOLD or REPEAT)
// -----------------------------------------------------------------------------
module ee201_pb_debouncer #(
    parameter int N_DEBOUNCE = 3,
    parameter int N_HOLD     = 60,
    parameter int N_REPEAT   = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clk60,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    // Terminal counts. The counter compares against N-1, so a value of
    // 2^CNT_WIDTH still fits in CNT_WIDTH bits.
    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(N_DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(N_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(N_REPEAT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HOLD        = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } state_t;

    state_t                 state_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic                   pb_meta_reg;
    logic                   pb_s_reg;
    logic                   clk60_d_reg;
    logic                   dpb_reg;
    logic                   scen_reg;
    logic                   mcen_reg;
    logic                   ccen_reg;
    logic                   tick;

    // Two-flop synchronizer for the raw button. Clk60 is already in the Clk
    // domain, so it only needs the one delay flop used for edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pb_meta_reg <= 1'b0;
            pb_s_reg    <= 1'b0;
            clk60_d_reg <= 1'b0;
        end else begin
            pb_meta_reg <= PB;
            pb_s_reg    <= pb_meta_reg;
            clk60_d_reg <= Clk60;
        end
    end

    // One tick per Clk60 rising edge. A Clk60 level stuck high yields no
    // further ticks.
    assign tick = Clk60 & ~clk60_d_reg;

    // Debounce / auto-repeat FSM. Outputs are registered alongside the state.
    // DPB and CCEN are updated on each transition into their target state.
    // SCEN and MCEN default low, so each one is a single-cycle pulse in the
    // first cycle of the destination state. Ticks are at least two Clk apart,
    // so two pulses can never be adjacent. In every state the pb_s check comes
    // before the tick check, so an input change wins over a coincident
    // terminal tick and no pulse is emitted.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dpb_reg   <= 1'b0;
            scen_reg  <= 1'b0;
            mcen_reg  <= 1'b0;
            ccen_reg  <= 1'b0;
        end else begin
            scen_reg <= 1'b0;
            mcen_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pb_s_reg) begin
                        state_reg <= DEB_PRESS;
                        cnt_reg   <= '0;
                    end
                end

                DEB_PRESS: begin
                    if (!pb_s_reg) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (tick) begin
                        if (cnt_reg == DEB_LAST) begin
                            state_reg <= HOLD;
                            cnt_reg   <= '0;
                            dpb_reg   <= 1'b1;
                            ccen_reg  <= 1'b1;
                            scen_reg  <= 1'b1;
                            mcen_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end

                HOLD: begin
                    if (!pb_s_reg) begin
                        state_reg <= DEB_RELEASE;
                        cnt_reg   <= '0;
                        ccen_reg  <= 1'b0;
                    end else if (tick) begin
                        if (cnt_reg == HOLD_LAST) begin
                            state_reg <= REPEAT;
                            cnt_reg   <= '0;
                            mcen_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end

                REPEAT: begin
                    if (!pb_s_reg) begin
                        state_reg <= DEB_RELEASE;
                        cnt_reg   <= '0;
                        ccen_reg  <= 1'b0;
                    end else if (tick) begin
                        // Staying in REPEAT: the period restarts from zero.
                        if (cnt_reg == REP_LAST) begin
                            cnt_reg  <= '0;
                            mcen_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end

                DEB_RELEASE: begin
                    // A bounce back to 1 is the same press continuing. Return
                    // to HOLD quietly, with a fresh hold count.
                    if (pb_s_reg) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                        ccen_reg  <= 1'b1;
                    end else if (tick) begin
                        if (cnt_reg == DEB_LAST) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            dpb_reg   <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    dpb_reg   <= 1'b0;
                    ccen_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign DPB  = dpb_reg;
    assign SCEN = scen_reg;
    assign MCEN = mcen_reg;
    assign CCEN = ccen_reg;

endmodule

// File: tb/tb_ee201_pb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_ee201_pb_debouncer
//
// Drives directed button scenarios and a randomized PB sequence into the
// debouncer, using short debounce, hold and repeat lengths. Clk60 is a
// 5-high / 5-low level. Every cycle, the outputs are compared with a
// behavioural model of the button. The model keeps an accepted level, a
// pending-change flag, and tick counts. Auto-repeat pulses come from
// arithmetic on the number of ticks held.
// -----------------------------------------------------------------------------
module tb_ee201_pb_debouncer;

    localparam int N_DEB  = 3;
    localparam int N_HOLD = 4;
    localparam int N_REP  = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    logic Clk60 = 1'b0;
    logic PB    = 1'b0;
    logic DPB, SCEN, MCEN, CCEN;

    ee201_pb_debouncer #(
        .N_DEBOUNCE (N_DEB),
        .N_HOLD     (N_HOLD),
        .N_REPEAT   (N_REP),
        .CNT_WIDTH  (8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Clk60 (Clk60),
        .PB    (PB),
        .DPB   (DPB),
        .SCEN  (SCEN),
        .MCEN  (MCEN),
        .CCEN  (CCEN)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ph60   = 0;
    bit stuck60 = 1'b0;

    // Input history seen by the model: PB from the previous two edges,
    // and Clk60 from the previous edge.
    bit h1, h2, c60_prev;

    // Behavioural button model.
    bit m_dpb;       // accepted (debounced) level
    bit m_pending;   // a change away from m_dpb is waiting to be debounced
    int m_deb;       // ticks the pending change has survived
    int m_held;      // ticks since the press was (re)established
    bit exp_scen, exp_mcen;

    // Per-segment tallies.
    int obs_scen_n, obs_mcen_n, obs_dpb_n, exp_mcen_n;

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        h1 = 0; h2 = 0; c60_prev = 0;
        m_dpb = 0; m_pending = 0; m_deb = 0; m_held = 0;
        exp_scen = 0; exp_mcen = 0;
    endtask

    // Applies one Clk edge to the model, using the inputs held across that edge.
    task automatic model_edge();
        bit pb_s, tk;
        pb_s = h2;
        tk   = Clk60 && !c60_prev;
        h2 = h1; h1 = PB; c60_prev = Clk60;
        exp_scen = 0; exp_mcen = 0;
        if (!m_dpb) begin
            if (!pb_s) begin
                m_pending = 0; m_deb = 0;
            end else if (!m_pending) begin
                m_pending = 1; m_deb = 0;
            end else if (tk) begin
                m_deb++;
                if (m_deb == N_DEB) begin
                    m_dpb = 1; m_pending = 0; m_held = 0;
                    exp_scen = 1; exp_mcen = 1;
                end
            end
        end else if (m_pending) begin
            if (pb_s) begin
                m_pending = 0; m_held = 0;
            end else if (tk) begin
                m_deb++;
                if (m_deb == N_DEB) begin
                    m_dpb = 0; m_pending = 0;
                end
            end
        end else if (!pb_s) begin
            m_pending = 1; m_deb = 0;
        end else if (tk) begin
            m_held++;
            if (m_held == N_HOLD || (m_held > N_HOLD && (m_held - N_HOLD) % N_REP == 0))
                exp_mcen = 1;
        end
    endtask

    task automatic check_outputs();
        check_bit("dpb",  DPB,  m_dpb);
        check_bit("scen", SCEN, exp_scen);
        check_bit("mcen", MCEN, exp_mcen);
        check_bit("ccen", CCEN, m_dpb && !m_pending);
        obs_scen_n += int'(SCEN);
        obs_mcen_n += int'(MCEN);
        obs_dpb_n  += int'(DPB);
        exp_mcen_n += int'(exp_mcen);
    endtask

    // One Clk cycle: set the inputs, take the edge, update the model, then
    // sample the outputs 1 ns after the edge.
    task automatic cycle(input bit pb_v);
        PB    = pb_v;
        Clk60 = stuck60 ? 1'b1 : (ph60 < 5);
        ph60  = (ph60 + 1) % 10;
        @(posedge Clk);
        cyc++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input bit pb_v, input int n);
        for (int i = 0; i < n; i++) cycle(pb_v);
    endtask

    task automatic seg_begin();
        obs_scen_n = 0; obs_mcen_n = 0; obs_dpb_n = 0; exp_mcen_n = 0;
    endtask

    task automatic seg_end(input string name);
        $display("seg %s: cycle=%0d scen=%0d mcen=%0d (model %0d) dpb_cycles=%0d",
                 name, cyc, obs_scen_n, obs_mcen_n, exp_mcen_n, obs_dpb_n);
    endtask

    // Asynchronous reset asserted mid-cycle. The outputs must clear before
    // the next Clk edge.
    task automatic async_reset();
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_bit("rst_async_dpb",  DPB,  1'b0);
        check_bit("rst_async_scen", SCEN, 1'b0);
        check_bit("rst_async_mcen", MCEN, 1'b0);
        check_bit("rst_async_ccen", CCEN, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        check_bit("rst_hold_dpb",  DPB,  1'b0);
        check_bit("rst_hold_ccen", CCEN, 1'b0);
        Reset = 1'b1;
    endtask

    initial begin
        model_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_bit("reset_dpb",  DPB,  1'b0);
        check_bit("reset_scen", SCEN, 1'b0);
        check_bit("reset_mcen", MCEN, 1'b0);
        check_bit("reset_ccen", CCEN, 1'b0);
        Reset = 1'b1;

        // Clean press, then a clean release.
        seg_begin();
        run(1'b1, 60);
        check_int("clean_scen_count", obs_scen_n, 1);
        check_int("clean_mcen_count", obs_mcen_n, 1);
        check_bit("clean_dpb_held", DPB, 1'b1);
        check_bit("clean_ccen_held", CCEN, 1'b1);
        seg_end("clean_press");
        seg_begin();
        run(1'b0, 60);
        check_bit("clean_dpb_released", DPB, 1'b0);
        check_int("clean_release_scen", obs_scen_n, 0);
        seg_end("clean_release");

        // Bouncing input: never stable for a debounce window.
        seg_begin();
        for (int i = 0; i < 40; i++) cycle(((i / 3) % 2) == 0);
        run(1'b0, 40);
        check_int("bounce_dpb_cycles", obs_dpb_n, 0);
        check_int("bounce_scen_count", obs_scen_n, 0);
        check_int("bounce_mcen_count", obs_mcen_n, 0);
        seg_end("bounce");

        // Auto-repeat.
        seg_begin();
        run(1'b1, 200);
        check_int("repeat_scen_count", obs_scen_n, 1);
        check_int("repeat_mcen_count", obs_mcen_n, exp_mcen_n);
        check_bit("repeat_mcen_many", obs_mcen_n >= 6, 1'b1);
        seg_end("auto_repeat");

        // Release with one bounce back to pressed.
        seg_begin();
        run(1'b0, 10);
        run(1'b1, 10);
        run(1'b0, 15);
        check_bit("relbounce_dpb_still_high", DPB, 1'b1);
        run(1'b0, 45);
        check_bit("relbounce_dpb_low", DPB, 1'b0);
        check_int("relbounce_scen_count", obs_scen_n, 0);
        seg_end("release_bounce");

        // Reset while in REPEAT, then a full new press with PB still held.
        seg_begin();
        run(1'b1, 120);
        check_bit("mid_in_repeat", obs_mcen_n >= 2, 1'b1);
        check_bit("mid_ccen_before_reset", CCEN, 1'b1);
        async_reset();
        seg_end("reset_mid_hold");
        seg_begin();
        run(1'b1, 80);
        check_int("postreset_scen_count", obs_scen_n, 1);
        check_bit("postreset_dpb", DPB, 1'b1);
        run(1'b0, 60);
        seg_end("post_reset_press");

        // Clk60 stuck high: no ticks, so no press is ever accepted.
        seg_begin();
        stuck60 = 1'b1;
        run(1'b1, 100);
        check_int("stuck_dpb_cycles", obs_dpb_n, 0);
        check_int("stuck_scen_count", obs_scen_n, 0);
        stuck60 = 1'b0;
        run(1'b1, 60);
        check_int("unstuck_scen_count", obs_scen_n, 1);
        run(1'b0, 60);
        seg_end("clk60_stuck");

        // Randomized PB runs of varying length.
        seg_begin();
        for (int r = 0; r < 30; r++) begin
            int len;
            bit v;
            len = $urandom_range(1, 60);
            v   = 1'($urandom_range(0, 1));
            run(v, len);
        end
        check_int("random_mcen_count", obs_mcen_n, exp_mcen_n);
        seg_end("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
